// File: rtl/tx_symbol_mux_skp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tx_symbol_mux_skp                                                 |
// | Brief   : Registered TX symbol mux (data / framing / ordered-set / COM)     |
// |           with optional periodic SKP ordered-set insertion, enabled by the  |
// |           TX_MUX_SKP_INSERT_EN macro.                                       |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tx_symbol_mux_skp #(
  parameter int               WIDTH        = 8,
  parameter int               SKP_INTERVAL = 1180,
  parameter int               SKP_LEN      = 3,
  parameter logic [WIDTH-1:0] COM_CHAR     = 'hBC,
  parameter logic [WIDTH-1:0] SKP_CHAR     = 'h1C,
  parameter logic [WIDTH-1:0] IDL_CHAR     = 'h7C
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [WIDTH-1:0] start_end,
  input  logic [WIDTH-1:0] ordered_set,
  output logic             sel_ready,
  output logic [WIDTH-1:0] D_out,
  output logic             valid,
  output logic             k_out,
  output logic             skp_active
);

  logic [WIDTH-1:0] w_sym;
  logic             w_valid;
  logic             w_k;

  // Symbol chosen by the upstream control while in normal operation
  always_comb begin
    w_sym   = IDL_CHAR;
    w_valid = 1'b0;
    w_k     = 1'b1;
    case (control)
      2'b00: begin
        if (data_valid) begin
          w_sym   = data_in;
          w_valid = 1'b1;
          w_k     = 1'b0;
        end
      end
      2'b01:   w_sym = start_end;
      2'b10:   w_sym = ordered_set;
      default: w_sym = COM_CHAR;
    endcase
  end

`ifdef TX_MUX_SKP_INSERT_EN
  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SKP_COM = 2'd1,
    ST_SKP_SYM = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(SKP_INTERVAL);
  localparam int SYM_W = ($clog2(SKP_LEN) > 0) ? $clog2(SKP_LEN) : 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_skp_cnt;
  logic [SYM_W-1:0] r_sym_cnt;

  assign sel_ready  = (r_state == ST_NORMAL);
  assign data_ready = sel_ready && (control == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_NORMAL;
      r_skp_cnt  <= '0;
      r_sym_cnt  <= '0;
      D_out      <= '0;
      valid      <= 1'b0;
      k_out      <= 1'b0;
      skp_active <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          D_out      <= w_sym;
          valid      <= w_valid;
          k_out      <= w_k;
          skp_active <= 1'b0;
          // The terminal-count cycle still carries a normal selection
          if (r_skp_cnt == CNT_W'(SKP_INTERVAL - 1)) begin
            r_skp_cnt <= '0;
            r_state   <= ST_SKP_COM;
          end else begin
            r_skp_cnt <= r_skp_cnt + 1'b1;
          end
        end
        ST_SKP_COM: begin
          D_out      <= COM_CHAR;
          valid      <= 1'b0;
          k_out      <= 1'b1;
          skp_active <= 1'b1;
          r_sym_cnt  <= '0;
          r_state    <= ST_SKP_SYM;
        end
        ST_SKP_SYM: begin
          D_out      <= SKP_CHAR;
          valid      <= 1'b0;
          k_out      <= 1'b1;
          skp_active <= 1'b1;
          if (r_sym_cnt == SYM_W'(SKP_LEN - 1)) begin
            r_state <= ST_NORMAL;
          end else begin
            r_sym_cnt <= r_sym_cnt + 1'b1;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end
`else
  logic w_unused_cfg;

  // Interval/length only matter when insertion is compiled in
  assign w_unused_cfg = ^{SKP_INTERVAL, SKP_LEN, SKP_CHAR};
  assign sel_ready    = 1'b1;
  assign data_ready   = (control == 2'b00);
  assign skp_active   = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      D_out <= '0;
      valid <= 1'b0;
      k_out <= 1'b0;
    end else begin
      D_out <= w_sym;
      valid <= w_valid;
      k_out <= w_k;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_symbol_mux_skp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_tx_symbol_mux_skp                                              |
// | Brief   : Directed self-checking bench for tx_symbol_mux_skp (SKP_INTERVAL=8|
// |           SKP_LEN=3); SKP scenarios follow TX_MUX_SKP_INSERT_EN.            |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_tx_symbol_mux_skp;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] control = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [7:0] start_end = 8'h00;
  logic [7:0] ordered_set = 8'h00;
  logic       sel_ready;
  logic [7:0] D_out;
  logic       valid;
  logic       k_out;
  logic       skp_active;

  int n_checks = 0;
  int n_fail   = 0;

  tx_symbol_mux_skp #(
    .WIDTH       (8),
    .SKP_INTERVAL(8),
    .SKP_LEN     (3),
    .COM_CHAR    (8'hBC),
    .SKP_CHAR    (8'h1C),
    .IDL_CHAR    (8'h7C)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .control    (control),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .start_end  (start_end),
    .ordered_set(ordered_set),
    .sel_ready  (sel_ready),
    .D_out      (D_out),
    .valid      (valid),
    .k_out      (k_out),
    .skp_active (skp_active)
  );

  always #5 clk = ~clk;

  // Outputs packed as {D_out, valid, k_out, skp_active}
  function automatic logic [10:0] obs();
    return {D_out, valid, k_out, skp_active};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; release lands away from the next edge
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", obs(), 11'h000);
    end
    n_checks++;
    if ({sel_ready, data_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 11", {sel_ready, data_ready});
    end
    tick();
    n_checks++;
    if (obs() !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs(), 11'h000);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_data();
    do_reset();
    control = 2'b00; data_valid = 1'b1; data_in = 8'hA5;
    #1;
    n_checks++;
    if (data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL data_ready: got %b want 1", data_ready);
    end
    tick();
    n_checks++;
    if (obs() !== {8'hA5, 3'b100}) begin
      n_fail++;
      $display("FAIL data_A5: got %h want %h", obs(), {8'hA5, 3'b100});
    end
    data_valid = 1'b0;
  endtask

  task automatic test_controls();
    logic [1:0]  ctl [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [10:0] exp [4] = '{{8'hFB, 3'b010}, {8'h3C, 3'b010},
                             {8'hBC, 3'b010}, {8'h7C, 3'b010}};
    do_reset();
    start_end = 8'hFB; ordered_set = 8'h3C; data_in = 8'h55; data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      control = ctl[i];
      #1;
      n_checks++;
      if (data_ready !== (ctl[i] == 2'b00)) begin
        n_fail++;
        $display("FAIL ctl_ready[%0d]: got %b want %b", i, data_ready, ctl[i] == 2'b00);
      end
      tick();
      n_checks++;
      if (obs() !== exp[i]) begin
        n_fail++;
        $display("FAIL ctl_sym[%0d]: got %h want %h", i, obs(), exp[i]);
      end
    end
    control = 2'b00;
  endtask

`ifdef TX_MUX_SKP_INSERT_EN
  task automatic test_stream();
    logic [7:0] exp_d [19] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                               8'hBC, 8'h1C, 8'h1C, 8'h1C,
                               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    logic [7:0]  nxt = 8'h01;
    logic        skp;
    int          low = 0;
    logic        rdy;
    do_reset();
    control = 2'b00; data_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      data_in = nxt;
      #1;
      rdy = data_ready;
      if (!rdy) low++;
      n_checks++;
      if (sel_ready !== rdy) begin
        n_fail++;
        $display("FAIL stream_sel[%0d]: got %b want %b", i, sel_ready, rdy);
      end
      tick();
      if (rdy) nxt = nxt + 8'h01;
      skp = (i >= 8 && i <= 11);
      n_checks++;
      if (obs() !== {exp_d[i], ~skp, skp, skp}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h want %h", i, obs(), {exp_d[i], ~skp, skp, skp});
      end
    end
    n_checks++;
    if (low !== 4) begin
      n_fail++;
      $display("FAIL stream_ready_low: got %0d want 4", low);
    end
  endtask

  task automatic test_reset_mid_skp();
    // Continues the stream: cycle 19 is the 8th normal cycle, then BC, 1C
    data_in = 8'h10;
    tick();
    tick();
    n_checks++;
    if (obs() !== {8'hBC, 3'b011}) begin
      n_fail++;
      $display("FAIL skp2_com: got %h want %h", obs(), {8'hBC, 3'b011});
    end
    tick();
    n_checks++;
    if (obs() !== {8'h1C, 3'b011}) begin
      n_fail++;
      $display("FAIL skp2_sym: got %h want %h", obs(), {8'h1C, 3'b011});
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({obs(), sel_ready} !== 12'h001) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", {obs(), sel_ready}, 12'h001);
    end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h20 + 8'(i);
      tick();
      n_checks++;
      if (obs() !== {8'h20 + 8'(i), 3'b100}) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got %h want %h", i, obs(), {8'h20 + 8'(i), 3'b100});
      end
    end
    tick();
    n_checks++;
    if (obs() !== {8'hBC, 3'b011}) begin
      n_fail++;
      $display("FAIL post_reset_com: got %h want %h", obs(), {8'hBC, 3'b011});
    end
  endtask
`else
  task automatic test_no_skp();
    do_reset();
    control = 2'b00; data_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_in = 8'(i + 1);
      #1;
      n_checks++;
      if ({data_ready, sel_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL noskp_ready[%0d]: got %b want 11", i, {data_ready, sel_ready});
      end
      tick();
      n_checks++;
      if (obs() !== {8'(i + 1), 3'b100}) begin
        n_fail++;
        $display("FAIL noskp_sym[%0d]: got %h want %h", i, obs(), {8'(i + 1), 3'b100});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    tick();
    test_data();
    test_controls();
`ifdef TX_MUX_SKP_INSERT_EN
    test_stream();
    test_reset_mid_skp();
`else
    test_no_skp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
